pmem_arbiter: RTL

Parametrised N-channel arbiter that multiplexes cache-line requests from several cache clients (I-cache, D-cache, later L2 slices or a prefetcher) onto the single physical-memory port. It sits between the cache hierarchy and pmem, replacing the fixed two-client hookup with a configurable channel count and a selectable arbitration policy. Exactly one pmem transaction is in flight at a time; each is latched at grant and held stable until `pmem_resp`.

---
 rtl/pmem_arbiter_pkg.sv | 12 +
 rtl/pmem_arbiter_rr_grant.sv | 47 ++++
 rtl/pmem_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/pmem_arbiter_pkg.sv
// Shared types and limits for the pmem arbiter.
package arb_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam int MAX_CH = 8;

endpackage

// File: rtl/pmem_arbiter_rr_grant.sv
// Combinational grant selector: first requester found scanning from the
// pointer (round-robin) or from channel 0 (fixed priority).
module rr_grant #(
    parameter int NUM_CH = 2,
    parameter int PTR_W  = 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    input  logic              rr_mode,
    output logic [NUM_CH-1:0] grant,
    output logic [PTR_W-1:0]  idx,
    output logic              any
);

    int               cand_s;
    logic [PTR_W-1:0] cand_idx_s;

    // Walk the channels in search order and keep the first hit.
    always_comb begin
        grant      = '0;
        idx        = '0;
        any        = 1'b0;
        cand_s     = 0;
        cand_idx_s = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rr_mode) begin
                cand_s = int'(ptr) + k;
            end else begin
                cand_s = k;
            end
            if (cand_s >= NUM_CH) begin
                cand_s = cand_s - NUM_CH;
            end else begin
                cand_s = cand_s;
            end
            cand_idx_s = cand_s[PTR_W-1:0];
            if (!any && req[cand_idx_s]) begin
                any               = 1'b1;
                grant[cand_idx_s] = 1'b1;
                idx               = cand_idx_s;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// N-channel arbiter funnelling cache-line requests onto the single pmem port;
// one transaction in flight, latched at grant and held until pmem_resp.
module pmem_arbiter
    import arb_types::*;
#(
    parameter int NUM_CH  = 2,
    parameter int LINE_W  = 256,
    parameter int ADDR_W  = 32,
    parameter int RR_MODE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*ADDR_W-1:0] ch_address,
    input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
    output logic [NUM_CH-1:0]        ch_resp,
    output logic [LINE_W-1:0]        ch_rdata,
    output logic                     pmem_read,
    output logic                     pmem_write,
    output logic [ADDR_W-1:0]        pmem_address,
    output logic [LINE_W-1:0]        pmem_wdata,
    input  logic                     pmem_resp,
    input  logic [LINE_W-1:0]        pmem_rdata
);

    localparam int               PTR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(NUM_CH - 1);

    arb_state_t        state_r, state_next_s;
    logic [PTR_W-1:0]  ptr_r, gnt_idx_r, req_idx_s;
    logic [NUM_CH-1:0] req_s, req_grant_s, ch_resp_s;
    logic              req_any_s, op_write_s, grant_fire_s, resp_fire_s;
    logic [ADDR_W-1:0] addr_sel_s, pmem_address_r;
    logic [LINE_W-1:0] wdata_sel_s, pmem_wdata_r;
    logic              pmem_read_r, pmem_write_r;

    assign req_s = ch_read | ch_write;

    rr_grant #(
        .NUM_CH (NUM_CH),
        .PTR_W  (PTR_W)
    ) u_rr_grant (
        .req     (req_s),
        .ptr     (ptr_r),
        .rr_mode (RR_MODE != 0),
        .grant   (req_grant_s),
        .idx     (req_idx_s),
        .any     (req_any_s)
    );

    assign grant_fire_s = (state_r == IDLE) && req_any_s;
    assign resp_fire_s  = (state_r == BUSY) && pmem_resp;
    // A write on the granted channel takes precedence over a simultaneous read.
    assign op_write_s   = |(req_grant_s & ch_write);

    // One-hot mux of the granted channel's address and write line.
    always_comb begin
        addr_sel_s  = '0;
        wdata_sel_s = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            addr_sel_s  = addr_sel_s  | ({ADDR_W{req_grant_s[k]}} & ch_address[k*ADDR_W +: ADDR_W]);
            wdata_sel_s = wdata_sel_s | ({LINE_W{req_grant_s[k]}} & ch_wdata[k*LINE_W +: LINE_W]);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; DONE is a dead cycle letting the client drop its request.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = req_any_s   ? BUSY : IDLE;
            BUSY:    state_next_s = resp_fire_s ? DONE : BUSY;
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Transaction latches, pmem strobes and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_idx_r      <= '0;
            ptr_r          <= '0;
            pmem_address_r <= '0;
            pmem_wdata_r   <= '0;
            pmem_read_r    <= 1'b0;
            pmem_write_r   <= 1'b0;
        end else if (grant_fire_s) begin
            gnt_idx_r      <= req_idx_s;
            pmem_address_r <= addr_sel_s;
            pmem_wdata_r   <= wdata_sel_s;
            pmem_write_r   <= op_write_s;
            pmem_read_r    <= ~op_write_s;
            if (RR_MODE != 0) begin
                ptr_r <= (req_idx_s == LAST_CH) ? '0 : req_idx_s + PTR_W'(1);
            end else begin
                ptr_r <= ptr_r;
            end
        end else if (resp_fire_s) begin
            pmem_read_r  <= 1'b0;
            pmem_write_r <= 1'b0;
        end else begin
            pmem_read_r  <= pmem_read_r;
            pmem_write_r <= pmem_write_r;
        end
    end

    // Completion pulse routed to the granted channel in the pmem_resp cycle.
    always_comb begin
        ch_resp_s = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            ch_resp_s[k] = resp_fire_s && (gnt_idx_r == PTR_W'(k));
        end
    end

    assign ch_resp      = ch_resp_s;
    assign ch_rdata     = pmem_rdata;
    assign pmem_read    = pmem_read_r;
    assign pmem_write   = pmem_write_r;
    assign pmem_address = pmem_address_r;
    assign pmem_wdata   = pmem_wdata_r;

endmodule
